mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage, directly downstream of the EX/MEM register. Consumes its address (ALU result),
//  store data (D2), destination register and control bits. Runs a req/ack transaction to data memory,
//  stalls the upstream pipeline while the access is outstanding, and produces the MEM/WB register
//  outputs for the write-back mux. Bubbles, loads, stores and ALU-only instructions all pass through it.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles in ACCESS without dmem_ack before bus error (>=2)
// PORTS
//  clock          in   1   rising-edge clock
//  reset          in   1   asynchronous, active-high
//  MEM_Valid      in   1   EX/MEM slot holds a real instruction
//  MEM_ALUResult  in   32  address for load/store; result for ALU ops
//  MEM_D2         in   32  store data
//  MEM_RD         in   5   destination register
//  MEM_RegWrite   in   1   instruction writes the register file
//  MEM_MemToReg   in   1   write-back selects load data
//  MEM_MEM_WEN    in   1   store
//  MEM_MEM_REN    in   1   load
//  dmem_req       out  1   memory request, registered
//  dmem_we        out  1   1=write, 0=read, registered
//  dmem_addr      out  32  word address, registered
//  dmem_wdata     out  32  store data, registered
//  dmem_ack       in   1   access complete; rdata valid in the same cycle
//  dmem_rdata     in   32  load data
//  mem_stall      out  1   combinational; freezes PC, IF/ID, ID/EX and EX/MEM
//  mem_bus_err    out  1   one-cycle pulse on timeout
//  WB_Valid, WB_RegWrite, WB_MemToReg  out 1   MEM/WB control
//  WB_RD          out  5   MEM/WB destination
//  WB_ALUResult   out  32  MEM/WB ALU result
//  WB_ReadData    out  32  MEM/WB load data
// BEHAVIOUR
//  Reset: all outputs 0. State is IDLE and the timeout counter is 0. Reset mid-access drops dmem_req at once.
//  memop = MEM_Valid & (MEM_MEM_REN | MEM_MEM_WEN). If WEN and REN are both set, it is a store (WEN wins)
//    and RegWrite is forced 0.
//  FSM IDLE:
//    - no memop: MEM/WB captures the inputs on the next edge, WB_Valid=MEM_Valid, stall=0 (0 extra latency).
//    - memop: stall=1. Latch the address, wdata and we into the dmem_* registers, set dmem_req=1, go to ACCESS.
//  FSM ACCESS:
//    - dmem_req is held and the address and data are stable. Counter increments each cycle.
//    - stall = ~dmem_ack.
//    - ack: MEM/WB captures the inputs, with ReadData=dmem_rdata for loads and 0 for stores. WB_Valid=1.
//      dmem_req is cleared and the FSM returns to IDLE. EX/MEM advances on the same edge.
//    - counter==TIMEOUT_CYCLES-1 without ack: clear dmem_req and pulse mem_bus_err. Release the stall.
//      MEM/WB captures the instruction with WB_RegWrite=0 and WB_Valid=1, then return to IDLE.
//    - ack on the timeout cycle: treated as a normal ack, no error.
//  While stalled, MEM/WB is loaded with a bubble (WB_Valid=0, WB_RegWrite=0); data fields hold their values.
//  Minimum memory-op latency is 2 cycles (issue + ack). Back-to-back memops get no IDLE gap beyond the issue cycle.
//  Address bits [1:0] go to dmem_addr unmodified.
// CONFIGURATION
//  MEM_MISALIGN_CHECK_EN defined:
//    - a memop with ALUResult[1:0]!=0 issues no request.
//    - mem_bus_err pulses for 1 cycle and the instruction retires as a bubble with WB_RegWrite=0.
//    - stall=0 and the FSM stays in IDLE.
//  MEM_MISALIGN_CHECK_EN undefined: no check is made; the access is issued as-is.
// STRUCTURE
//  Shared package mips_pkg:
//    - typedef enum {IDLE, ACCESS} mem_state_t
//    - constants XLEN=32 and REG_AW=5
//  Sub-module mem_wb_reg: MEM/WB register with load and bubble controls, async reset.
//  FSM, counter and dmem_* registers stay in mem_stage.
// TESTING
//  1. ALU op (Valid=1, RegWrite=1, RD=5, ALUResult=0x1234, no memop) -> next cycle: WB_Valid=1, WB_RD=5,
//     WB_ALUResult=0x1234, stall never asserted.
//  2. Load addr 0x40, ack after 3 cycles with rdata=0xDEADBEEF -> stall high 3 cycles, dmem_req held
//     with addr 0x40, then WB_ReadData=0xDEADBEEF and WB_MemToReg=1.
//  3. Store addr 0x80, D2=0xCAFEF00D, ack on the first ACCESS cycle -> dmem_we=1, wdata=0xCAFEF00D,
//     WB_RegWrite=0, total stall 1 cycle.
//  4. Load with no ack, TIMEOUT_CYCLES=4 -> req drops after 4 ACCESS cycles, one bus_err pulse,
//     WB_RegWrite=0, then IDLE.
//  5. reset asserted mid-ACCESS -> dmem_req=0, stall=0, WB_*=0 immediately. After release, a new load issues normally.
//  6. (MEM_MISALIGN_CHECK_EN) load at 0x42 -> no dmem_req, bus_err pulse, WB_Valid=1 with WB_RegWrite=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Types and constants shared by the MIPS pipeline stages.
package mips_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the valid and write-enable bits
// and keeps the data fields, so a stall does not retire anything twice.
import mips_pkg::*;

module mem_wb_reg (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              bubble,
    input  logic              valid_next,
    input  logic              reg_write_next,
    input  logic              mem_to_reg_next,
    input  logic [REG_AW-1:0] rd_next,
    input  logic [XLEN-1:0]   alu_result_next,
    input  logic [XLEN-1:0]   read_data_next,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_alu_result,
    output logic [XLEN-1:0]   wb_read_data
);

    // Bubble takes priority over load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_rd         <= '0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
        end else if (bubble) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
        end else if (load) begin
            wb_valid      <= valid_next;
            wb_reg_write  <= reg_write_next;
            wb_mem_to_reg <= mem_to_reg_next;
            wb_rd         <= rd_next;
            wb_alu_result <= alu_result_next;
            wb_read_data  <= read_data_next;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory req/ack handshake, upstream stall,
// access timeout and the MEM/WB register.
// Optional build macro MEM_MISALIGN_CHECK_EN: memops with a non-word-aligned
// address are rejected with a bus error instead of being issued.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | no access outstanding; non-memops flow straight through
//   ACCESS | dmem_req held, waiting for dmem_ack or timeout
import mips_pkg::*;

module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MEM_Valid,
    input  logic [XLEN-1:0]   MEM_ALUResult,
    input  logic [XLEN-1:0]   MEM_D2,
    input  logic [REG_AW-1:0] MEM_RD,
    input  logic              MEM_RegWrite,
    input  logic              MEM_MemToReg,
    input  logic              MEM_MEM_WEN,
    input  logic              MEM_MEM_REN,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              mem_stall,
    output logic              mem_bus_err,
    output logic              WB_Valid,
    output logic              WB_RegWrite,
    output logic              WB_MemToReg,
    output logic [REG_AW-1:0] WB_RD,
    output logic [XLEN-1:0]   WB_ALUResult,
    output logic [XLEN-1:0]   WB_ReadData
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t       state;
    logic [CNT_W-1:0] count;

    logic memop;
    logic misaligned;
    logic issue;
    logic done;
    logic timeout_hit;
    logic wb_valid_next;
    logic wb_reg_write_next;
    logic [XLEN-1:0] wb_read_data_next;

    assign memop = MEM_Valid & (MEM_MEM_REN | MEM_MEM_WEN);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = memop & (|MEM_ALUResult[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign issue       = (state == IDLE) & memop & ~misaligned;
    assign done        = (state == ACCESS) & dmem_ack;
    assign timeout_hit = (state == ACCESS) & ~dmem_ack & (count == CNT_LAST);

    // Reset gating keeps the stall low while reset is held, even with a memop waiting.
    assign mem_stall = ~reset & (issue | ((state == ACCESS) & ~dmem_ack & ~timeout_hit));

    // Anything that completes in ACCESS (ack or timeout), or a rejected misaligned op, retires as valid.
    assign wb_valid_next     = ((state == IDLE) & ~misaligned) ? MEM_Valid : 1'b1;
    assign wb_reg_write_next = MEM_Valid & MEM_RegWrite & ~MEM_MEM_WEN & ~timeout_hit & ~misaligned;
    assign wb_read_data_next = (done & ~MEM_MEM_WEN) ? dmem_rdata : '0;

    // Access FSM, timeout counter and registered dmem_* interface.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            mem_bus_err <= 1'b0;
        end else begin
            mem_bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (issue) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= MEM_MEM_WEN;
                        dmem_addr  <= MEM_ALUResult;
                        dmem_wdata <= MEM_D2;
                        state      <= ACCESS;
                    end else if (misaligned) begin
                        mem_bus_err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (done) begin
                        dmem_req <= 1'b0;
                        count    <= '0;
                        state    <= IDLE;
                    end else if (timeout_hit) begin
                        dmem_req    <= 1'b0;
                        mem_bus_err <= 1'b1;
                        count       <= '0;
                        state       <= IDLE;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_wb_reg u_mem_wb_reg (
        .clock           (clock),
        .reset           (reset),
        .load            (~mem_stall),
        .bubble          (mem_stall),
        .valid_next      (wb_valid_next),
        .reg_write_next  (wb_reg_write_next),
        .mem_to_reg_next (MEM_MemToReg),
        .rd_next         (MEM_RD),
        .alu_result_next (MEM_ALUResult),
        .read_data_next  (wb_read_data_next),
        .wb_valid        (WB_Valid),
        .wb_reg_write    (WB_RegWrite),
        .wb_mem_to_reg   (WB_MemToReg),
        .wb_rd           (WB_RD),
        .wb_alu_result   (WB_ALUResult),
        .wb_read_data    (WB_ReadData)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes the expected MEM/WB
// contents per instruction, a monitor pops and compares on every WB_Valid.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        MEM_Valid = 1'b0;
    logic [31:0] MEM_ALUResult = '0;
    logic [31:0] MEM_D2 = '0;
    logic [4:0]  MEM_RD = '0;
    logic        MEM_RegWrite = 1'b0;
    logic        MEM_MemToReg = 1'b0;
    logic        MEM_MEM_WEN = 1'b0;
    logic        MEM_MEM_REN = 1'b0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        mem_stall, mem_bus_err;
    logic        WB_Valid, WB_RegWrite, WB_MemToReg;
    logic [4:0]  WB_RD;
    logic [31:0] WB_ALUResult, WB_ReadData;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        rw;
        logic        m2r;
    } wb_exp_t;

    wb_exp_t sb[$];

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .MEM_Valid(MEM_Valid), .MEM_ALUResult(MEM_ALUResult), .MEM_D2(MEM_D2),
        .MEM_RD(MEM_RD), .MEM_RegWrite(MEM_RegWrite), .MEM_MemToReg(MEM_MemToReg),
        .MEM_MEM_WEN(MEM_MEM_WEN), .MEM_MEM_REN(MEM_MEM_REN),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .mem_bus_err(mem_bus_err),
        .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg),
        .WB_RD(WB_RD), .WB_ALUResult(WB_ALUResult), .WB_ReadData(WB_ReadData)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every retirement must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset && WB_Valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got retirement rd=%0d alu=0x%0h, expected none", WB_RD, WB_ALUResult);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                check("wb_rd",        {27'd0, WB_RD},       {27'd0, e.rd});
                check("wb_aluresult", WB_ALUResult,          e.alu);
                check("wb_readdata",  WB_ReadData,           e.rdata);
                check("wb_regwrite",  {31'd0, WB_RegWrite},  {31'd0, e.rw});
                check("wb_memtoreg",  {31'd0, WB_MemToReg},  {31'd0, e.m2r});
            end
        end
    end

    task automatic drive_bubble();
        MEM_Valid = 1'b0; MEM_RegWrite = 1'b0; MEM_MemToReg = 1'b0;
        MEM_MEM_WEN = 1'b0; MEM_MEM_REN = 1'b0; MEM_RD = '0;
        MEM_ALUResult = '0; MEM_D2 = '0; dmem_ack = 1'b0;
    endtask

    // One instruction through the stage. ack_at: ACCESS cycle index that sees
    // dmem_ack (-1 = never). exp_req: a dmem request must be issued.
    task automatic run_op(input string tag, input logic rw, input logic m2r,
                          input logic wen, input logic ren, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] d2,
                          input int ack_at, input logic [31:0] rdata,
                          input int exp_stall, input logic exp_err, input logic exp_rw,
                          input logic [31:0] exp_rdata, input logic exp_req);
        int  cyc = 0;
        int  stalls = 0;
        bit  done = 0;
        sb.push_back(wb_exp_t'{rd, alu, exp_rdata, exp_rw, m2r});
        @(posedge clock); #1;
        MEM_Valid = 1'b1; MEM_RegWrite = rw; MEM_MemToReg = m2r;
        MEM_MEM_WEN = wen; MEM_MEM_REN = ren; MEM_RD = rd;
        MEM_ALUResult = alu; MEM_D2 = d2;
        while (!done && cyc < 40) begin
            dmem_ack   = exp_req && (cyc >= 1) && ((cyc - 1) == ack_at);
            dmem_rdata = dmem_ack ? rdata : 32'h5A5A_5A5A;
            @(negedge clock);
            if (mem_stall) stalls++;
            else done = 1;
            if (exp_req && cyc >= 1) begin
                check({tag, "_req"},  {31'd0, dmem_req}, 32'd1);
                check({tag, "_addr"}, dmem_addr, alu);
                check({tag, "_we"},   {31'd0, dmem_we}, {31'd0, wen});
                if (wen) check({tag, "_wdata"}, dmem_wdata, d2);
            end
            cyc++;
            @(posedge clock); #1;
        end
        drive_bubble();
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_complete: stall still high after %0d cycles, expected release", tag, cyc);
        end
        check({tag, "_stall_cycles"}, stalls, exp_stall);
        @(negedge clock);
        check({tag, "_bus_err"},  {31'd0, mem_bus_err}, {31'd0, exp_err});
        check({tag, "_req_done"}, {31'd0, dmem_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_req",     {31'd0, dmem_req},    32'd0);
        check("rst_stall",   {31'd0, mem_stall},   32'd0);
        check("rst_bus_err", {31'd0, mem_bus_err}, 32'd0);
        check("rst_wb_valid",{31'd0, WB_Valid},    32'd0);
        check("rst_wb_alu",  WB_ALUResult,         32'd0);
        check("rst_addr",    dmem_addr,            32'd0);
        @(negedge clock); @(negedge clock);
        reset = 1'b0;

        //     tag       rw    m2r   wen   ren   rd     alu           d2            ack rdata         st err  rw    exp_rdata     req
        run_op("alu",    1'b1, 1'b0, 1'b0, 1'b0, 5'd5,  32'h0000_1234, 32'h0,        -1, 32'h0,        0, 1'b0, 1'b1, 32'h0,        1'b0);
        run_op("alu2",   1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  32'hFFFF_FFFF, 32'h0,        -1, 32'h0,        0, 1'b0, 1'b0, 32'h0,        1'b0);
        run_op("load",   1'b1, 1'b1, 1'b0, 1'b1, 5'd7,  32'h0000_0040, 32'h0,         2, 32'hDEAD_BEEF, 3, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        run_op("store",  1'b0, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_0080, 32'hCAFE_F00D, 0, 32'h0,        1, 1'b0, 1'b0, 32'h0,        1'b1);
        run_op("tmo",    1'b1, 1'b1, 1'b0, 1'b1, 5'd9,  32'h0000_0044, 32'h0,        -1, 32'h0,        4, 1'b1, 1'b0, 32'h0,        1'b1);
        run_op("ack_tc", 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_0048, 32'h0,         3, 32'h1357_2468, 4, 1'b0, 1'b1, 32'h1357_2468, 1'b1);
        run_op("wen_ren",1'b1, 1'b1, 1'b1, 1'b1, 5'd11, 32'h0000_0050, 32'h0000_A5A5, 1, 32'h7777_7777, 2, 1'b0, 1'b0, 32'h0,        1'b1);

        // Reset in the middle of an access: leave data in MEM/WB, start a load, reset while in ACCESS.
        @(posedge clock); #1;
        MEM_Valid = 1'b0; MEM_RD = 5'd21; MEM_ALUResult = 32'h0000_0777;
        @(posedge clock); #1;
        MEM_Valid = 1'b1; MEM_RegWrite = 1'b1; MEM_MemToReg = 1'b1; MEM_MEM_REN = 1'b1;
        MEM_RD = 5'd14; MEM_ALUResult = 32'h0000_0100;
        @(posedge clock); #1;
        @(negedge clock);
        check("mid_req", {31'd0, dmem_req}, 32'd1);
        check("mid_wb_alu_held", WB_ALUResult, 32'h0000_0777);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_req",      {31'd0, dmem_req},   32'd0);
        check("rst_mid_stall",    {31'd0, mem_stall},  32'd0);
        check("rst_mid_wb_valid", {31'd0, WB_Valid},   32'd0);
        check("rst_mid_wb_rd",    {27'd0, WB_RD},      32'd0);
        check("rst_mid_wb_alu",   WB_ALUResult,        32'd0);
        drive_bubble();
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        run_op("load_post_rst", 1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_0060, 32'h0, 1, 32'h0BAD_F00D, 2, 1'b0, 1'b1, 32'h0BAD_F00D, 1'b1);

`ifdef MEM_MISALIGN_CHECK_EN
        run_op("misalign", 1'b1, 1'b1, 1'b0, 1'b1, 5'd13, 32'h0000_0042, 32'h0, -1, 32'h0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
`else
        run_op("unaligned", 1'b1, 1'b1, 1'b0, 1'b1, 5'd13, 32'h0000_0042, 32'h0, 0, 32'h1122_3344, 1, 1'b0, 1'b1, 32'h1122_3344, 1'b1);
`endif

        repeat (3) @(negedge clock);
        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
